eth_rx_filter: RTL and testbench
================================

ETH_RX_FILTER -- requirements
Module: eth_rx_filter

Interface
REQ-001 SHALL have parameter DATA_DEPTH, default 512, data FIFO depth in 64-bit beats (power of two).
REQ-002 SHALL have parameter VERDICT_DEPTH, default 8, verdict FIFO depth in frames (power of two).
REQ-003 SHALL have port clk156  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst156  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports eth_rx_tvalid/tdata/tkeep/tlast/tuser  in  1/64/8/1/1  MAC receive stream, no backpressure; byte k of a frame is beat k/8, lane k%8 (tdata[8*lane+7:8*lane]).
REQ-006 SHALL have ports fil_rx_tvalid/tdata/tkeep/tlast  out  1/64/8/1  filtered stream toward the decapsulator.
REQ-007 SHALL have port fil_rx_tready  in  1  downstream accept.
REQ-008 SHALL have ports adapter_reg_srcmac/srcip/srcport  in  48/32/16  local MAC, IP and UDP port base.
REQ-009 SHALL have ports stat_pass_cnt, stat_drop_cnt, stat_ovf_cnt  out  32 each  frame counters.

Function
REQ-010 SHALL pass a frame only if all hold: dst MAC (bytes 0-5) == adapter_reg_srcmac; ethertype (bytes 12-13) == 0x0800; IP protocol (byte 23) == 17; dst IP (bytes 30-33) == adapter_reg_srcip; UDP dst port (bytes 36-37) bits [15:4] == adapter_reg_srcport[15:4]; no beat had tuser=1; frame has at least 5 beats; no overflow.
REQ-011 SHALL compare multi-byte fields in network byte order (lowest byte index = most significant).
REQ-012 SHALL write each accepted input beat (tdata, tkeep, tlast) into the data FIFO; SHALL push one verdict bit into the verdict FIFO in the cycle the tlast beat is written.
REQ-013 SHALL at frame start (first beat after reset or after a tlast) discard the whole frame without writing any beat if the verdict FIFO is full, incrementing stat_ovf_cnt at its tlast.
REQ-014 SHALL write a non-last beat only if data FIFO free entries >= 2; otherwise discard it and mark the frame overflowed (verdict drop, stat_ovf_cnt +1).
REQ-015 SHALL always write the tlast beat (one entry is guaranteed by REQ-014), preserving framing in the FIFO.
REQ-016 SHALL drain with FSM states IDLE, FWD, DISCARD: IDLE pops a verdict when the verdict FIFO is non-empty and enters FWD (pass) or DISCARD (drop); both return to IDLE after the tlast beat leaves the data FIFO.
REQ-017 SHALL in FWD present the FIFO head on fil_rx_*, fil_rx_tvalid = data FIFO non-empty, pop on tvalid & tready; tdata/tkeep/tlast SHALL be held stable while tvalid & !tready.
REQ-018 SHALL in DISCARD pop one beat per cycle regardless of fil_rx_tready, with fil_rx_tvalid = 0.
REQ-019 SHALL assert fil_rx_tvalid for a passed frame's first beat no later than 3 cycles after its input tlast beat, given fil_rx_tready = 1 and no older frames queued; back-to-back beats thereafter at full rate.
REQ-020 SHALL increment stat_pass_cnt when a FWD frame's tlast is popped and stat_drop_cnt when a DISCARD frame's tlast is popped; counters wrap at 2^32.
REQ-021 SHALL handle simultaneous write and pop on a full or empty FIFO correctly (free count unchanged when both occur).

Reset
REQ-022 SHALL on sys_rst156 asynchronously clear FIFO pointers, frame parser, FSM (IDLE), all counters, and drive fil_rx_tvalid = 0.
REQ-023 SHALL after reset release treat the next eth_rx_tvalid beat as frame start; a frame in flight at reset is lost, never partially output.

Configuration
REQ-024 SHALL with macro ETH_RX_FILTER_STATS_EN defined implement the three counters per REQ-013/014/020.
REQ-025 SHALL without ETH_RX_FILTER_STATS_EN tie stat_* outputs to 0 and instantiate no counter registers; filtering unchanged.

Verification
REQ-026 SHALL cover: matching 8-beat UDP frame (dst port 0x3005, srcport 0x3000) -> 8 identical beats out, stat_pass_cnt = 1.
REQ-027 SHALL cover: same frame with dst IP 192.168.10.2 vs register 192.168.10.1 -> no output, stat_drop_cnt = 1.
REQ-028 SHALL cover: matching frame with tuser = 1 on last beat, then a good frame -> only second frame output, counters pass=1 drop=1.
REQ-029 SHALL cover: 4-beat runt frame followed by matching frame -> runt dropped, good frame intact.
REQ-030 SHALL cover: DATA_DEPTH=16, fil_rx_tready = 0, 20-beat matching frame -> frame dropped, stat_ovf_cnt = 1, following frame passes after tready = 1.
REQ-031 SHALL cover: reset asserted mid-output of a passed frame -> fil_rx_tvalid falls immediately, next frame output complete and correct.

Source files
------------

// File: rtl/eth_rx_filter.sv
// eth_rx_filter: receive-side UDP frame filter with store-and-forward data and verdict FIFOs.
// Frame counters exist only when ETH_RX_FILTER_STATS_EN is defined; otherwise stat_* read 0.
module eth_rx_filter #(
  parameter int DATA_DEPTH    = 512,
  parameter int VERDICT_DEPTH = 8
) (
  input  logic        clk156,
  input  logic        sys_rst156,
  input  logic        eth_rx_tvalid,
  input  logic [63:0] eth_rx_tdata,
  input  logic [7:0]  eth_rx_tkeep,
  input  logic        eth_rx_tlast,
  input  logic        eth_rx_tuser,
  output logic        fil_rx_tvalid,
  output logic [63:0] fil_rx_tdata,
  output logic [7:0]  fil_rx_tkeep,
  output logic        fil_rx_tlast,
  input  logic        fil_rx_tready,
  input  logic [47:0] adapter_reg_srcmac,
  input  logic [31:0] adapter_reg_srcip,
  input  logic [15:0] adapter_reg_srcport,
  output logic [31:0] stat_pass_cnt,
  output logic [31:0] stat_drop_cnt,
  output logic [31:0] stat_ovf_cnt
);
  // Purpose: keep only UDP frames addressed to this adapter; verdict is known at tlast.
  // Latency: first beat of a passed frame is offered 2 cycles after its input tlast beat.
  // Backpressure: input never stalls (overflow drops the frame); output honours fil_rx_tready.

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int VAW = $clog2(VERDICT_DEPTH);
  localparam logic [DAW:0] DATA_ROOM2 = (DAW+1)'(DATA_DEPTH - 2);
  localparam logic [VAW:0] VERD_FULL  = (VAW+1)'(VERDICT_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FWD     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t          wr_beat;
  beat_t          head;
  logic [DAW:0]   data_cnt;
  logic [VAW:0]   verd_cnt;
  logic           data_wr;
  logic           data_rd;
  logic           verd_wr;
  logic           verd_rd;
  logic           verd_din;
  logic           verd_head;
  logic           data_empty;
  logic           verd_empty;
  logic           verd_full;
  logic           room2;

  assign data_empty = (data_cnt == '0);
  assign verd_empty = (verd_cnt == '0);
  assign verd_full  = (verd_cnt == VERD_FULL);
  assign room2      = (data_cnt <= DATA_ROOM2);

  // Input-side frame parser state
  logic       in_frame;
  logic       skip_q;
  logic       ovf_q;
  logic       ok_q;
  logic [2:0] beat_idx;

  logic       start;
  logic       skip_now;
  logic       ovf_now;
  logic       ovf_eff;
  logic       ok_eff;
  logic       field_ok;
  logic [2:0] idx;
  logic [7:0] lane [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane[i] = eth_rx_tdata[8*i +: 8];
    end
  end

  // Header fields are checked in network byte order as the beats that carry them arrive.
  always_comb begin
    field_ok = 1'b1;
    case (idx)
      3'd0: field_ok = ({lane[0], lane[1], lane[2], lane[3], lane[4], lane[5]} == adapter_reg_srcmac);
      3'd1: field_ok = ({lane[4], lane[5]} == 16'h0800);
      3'd2: field_ok = (lane[7] == 8'd17);
      3'd3: field_ok = ({lane[6], lane[7]} == adapter_reg_srcip[31:16]);
      3'd4: field_ok = ({lane[0], lane[1]} == adapter_reg_srcip[15:0]) &&
                       ((({lane[4], lane[5]} ^ adapter_reg_srcport) & 16'hfff0) == 16'h0000);
      default: field_ok = 1'b1;
    endcase
  end

  always_comb begin
    start    = !in_frame;
    skip_now = start ? verd_full : skip_q;
    idx      = start ? 3'd0 : beat_idx;
    ovf_now  = !skip_now && !eth_rx_tlast && !room2;
    ovf_eff  = (!start && ovf_q) || ovf_now;
    ok_eff   = (start || ok_q) && field_ok && !eth_rx_tuser;
    data_wr  = eth_rx_tvalid && !skip_now && (eth_rx_tlast || room2);
    verd_wr  = eth_rx_tvalid && eth_rx_tlast && !skip_now;
    verd_din = ok_eff && !ovf_eff && (idx >= 3'd4);
    wr_beat  = '{dat: eth_rx_tdata, keep: eth_rx_tkeep, last: eth_rx_tlast};
  end

  always_ff @(posedge clk156 or posedge sys_rst156) begin
    if (sys_rst156) begin
      in_frame <= 1'b0;
      skip_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ok_q     <= 1'b0;
      beat_idx <= 3'd0;
    end else if (eth_rx_tvalid) begin
      in_frame <= !eth_rx_tlast;
      skip_q   <= skip_now;
      ovf_q    <= ovf_eff;
      ok_q     <= ok_eff;
      beat_idx <= (idx == 3'd7) ? idx : idx + 3'd1;
    end
  end

  eth_rx_filter_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk    (clk156),
    .rst    (sys_rst156),
    .wr     (data_wr),
    .wr_dat (wr_beat),
    .rd     (data_rd),
    .rd_dat (head),
    .count  (data_cnt)
  );

  eth_rx_filter_fifo #(
    .WIDTH (1),
    .DEPTH (VERDICT_DEPTH)
  ) u_verdict_fifo (
    .clk    (clk156),
    .rst    (sys_rst156),
    .wr     (verd_wr),
    .wr_dat (verd_din),
    .rd     (verd_rd),
    .rd_dat (verd_head),
    .count  (verd_cnt)
  );

  // Drain side
  logic [1:0] state;
  logic       pop_last;

  always_comb begin
    fil_rx_tvalid = 1'b0;
    data_rd       = 1'b0;
    verd_rd       = 1'b0;
    case (state)
      ST_IDLE:    verd_rd = !verd_empty;
      ST_FWD: begin
        fil_rx_tvalid = !data_empty;
        data_rd       = !data_empty && fil_rx_tready;
      end
      ST_DISCARD: data_rd = !data_empty;
      default:    data_rd = 1'b0;
    endcase
    pop_last = data_rd && head.last;
  end

  always_ff @(posedge clk156 or posedge sys_rst156) begin
    if (sys_rst156) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (!verd_empty) state <= verd_head ? ST_FWD : ST_DISCARD;
        ST_FWD:     if (pop_last) state <= ST_IDLE;
        ST_DISCARD: if (pop_last) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign fil_rx_tdata = head.dat;
  assign fil_rx_tkeep = head.keep;
  assign fil_rx_tlast = head.last;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [31:0] pass_q;
  logic [31:0] drop_q;
  logic [31:0] ovf_cnt_q;

  always_ff @(posedge clk156 or posedge sys_rst156) begin
    if (sys_rst156) begin
      pass_q    <= 32'd0;
      drop_q    <= 32'd0;
      ovf_cnt_q <= 32'd0;
    end else begin
      if (pop_last && (state == ST_FWD))     pass_q <= pass_q + 32'd1;
      if (pop_last && (state == ST_DISCARD)) drop_q <= drop_q + 32'd1;
      if (eth_rx_tvalid && eth_rx_tlast && (skip_now || ovf_eff)) ovf_cnt_q <= ovf_cnt_q + 32'd1;
    end
  end

  assign stat_pass_cnt = pass_q;
  assign stat_drop_cnt = drop_q;
  assign stat_ovf_cnt  = ovf_cnt_q;
`else
  assign stat_pass_cnt = 32'd0;
  assign stat_drop_cnt = 32'd0;
  assign stat_ovf_cnt  = 32'd0;
`endif

endmodule

module eth_rx_filter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [WIDTH-1:0]        wr_dat,
  input  logic                    rd,
  output logic [WIDTH-1:0]        rd_dat,
  output logic [$clog2(DEPTH):0]  count
);
  // Purpose: generic power-of-two FIFO with the head visible combinationally.
  // Latency: a written entry is readable the cycle after the write.
  // Backpressure: writes while full are accepted only together with a pop.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign rd_ok  = rd && (count != '0);
  assign wr_ok  = wr && ((count != FULL_CNT) || rd_ok);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_filter.sv
// Directed bench for eth_rx_filter: frames built byte-wise, verdicts from a frame-level model.
`timescale 1ns/1ps
module tb_eth_rx_filter;

  localparam int DD = 16;
  localparam logic [47:0] MY_MAC  = 48'h02000A0B0C0D;
  localparam logic [31:0] MY_IP   = 32'hC0A80A01;
  localparam logic [15:0] MY_PORT = 16'h3000;

  logic        clk156 = 1'b0;
  logic        sys_rst156 = 1'b1;
  logic        eth_rx_tvalid = 1'b0;
  logic [63:0] eth_rx_tdata = '0;
  logic [7:0]  eth_rx_tkeep = '0;
  logic        eth_rx_tlast = 1'b0;
  logic        eth_rx_tuser = 1'b0;
  logic        fil_rx_tvalid;
  logic [63:0] fil_rx_tdata;
  logic [7:0]  fil_rx_tkeep;
  logic        fil_rx_tlast;
  logic        fil_rx_tready = 1'b1;
  logic [47:0] adapter_reg_srcmac = MY_MAC;
  logic [31:0] adapter_reg_srcip = MY_IP;
  logic [15:0] adapter_reg_srcport = MY_PORT;
  logic [31:0] stat_pass_cnt;
  logic [31:0] stat_drop_cnt;
  logic [31:0] stat_ovf_cnt;

  eth_rx_filter #(.DATA_DEPTH(DD), .VERDICT_DEPTH(8)) dut (
    .clk156              (clk156),
    .sys_rst156          (sys_rst156),
    .eth_rx_tvalid       (eth_rx_tvalid),
    .eth_rx_tdata        (eth_rx_tdata),
    .eth_rx_tkeep        (eth_rx_tkeep),
    .eth_rx_tlast        (eth_rx_tlast),
    .eth_rx_tuser        (eth_rx_tuser),
    .fil_rx_tvalid       (fil_rx_tvalid),
    .fil_rx_tdata        (fil_rx_tdata),
    .fil_rx_tkeep        (fil_rx_tkeep),
    .fil_rx_tlast        (fil_rx_tlast),
    .fil_rx_tready       (fil_rx_tready),
    .adapter_reg_srcmac  (adapter_reg_srcmac),
    .adapter_reg_srcip   (adapter_reg_srcip),
    .adapter_reg_srcport (adapter_reg_srcport),
    .stat_pass_cnt       (stat_pass_cnt),
    .stat_drop_cnt       (stat_drop_cnt),
    .stat_ovf_cnt        (stat_ovf_cnt)
  );

  always #3 clk156 = ~clk156;

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         m_pass = 0;
  int         m_drop = 0;
  int         m_ovf  = 0;
  int         out_cnt = 0;
  logic [7:0] fb [256];
  int         flen = 0;
  bit         fuser_last = 1'b0;
  bit         stall_en = 1'b0;
  bit         rdy_force = 1'b1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference frame: matching UDP/IPv4 frame, 60 bytes (8 beats, last beat 4 bytes).
  task automatic build_base(input int len);
    for (int i = 0; i < 256; i++) fb[i] = 8'(i) ^ 8'h5A;
    fb[0] = 8'h02; fb[1] = 8'h00; fb[2] = 8'h0A; fb[3] = 8'h0B; fb[4] = 8'h0C; fb[5] = 8'h0D;
    for (int i = 6; i < 12; i++) fb[i] = 8'(i + 11);
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[15] = 8'h00;
    fb[22] = 8'h40; fb[23] = 8'h11;
    fb[26] = 8'hC0; fb[27] = 8'hA8; fb[28] = 8'h0A; fb[29] = 8'h63;
    fb[30] = 8'hC0; fb[31] = 8'hA8; fb[32] = 8'h0A; fb[33] = 8'h01;
    fb[34] = 8'h12; fb[35] = 8'h34; fb[36] = 8'h30; fb[37] = 8'h05;
    flen = len;
    fuser_last = 1'b0;
  endtask

  function automatic bit model_pass();
    logic [47:0] mac;
    logic [15:0] etype;
    logic [31:0] ip;
    logic [15:0] port;
    int          nbeats;
    nbeats = (flen + 7) / 8;
    mac    = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    etype  = {fb[12], fb[13]};
    ip     = {fb[30], fb[31], fb[32], fb[33]};
    port   = {fb[36], fb[37]};
    return (nbeats >= 5) && (mac == MY_MAC) && (etype == 16'h0800) && (fb[23] == 8'd17) &&
           (ip == MY_IP) && (port[15:4] == MY_PORT[15:4]) && !fuser_last;
  endfunction

  task automatic send_frame(input bit exp_ovf);
    int    nb;
    bit    pass;
    beat_t b;
    nb   = (flen + 7) / 8;
    pass = model_pass() && !exp_ovf;
    for (int k = 0; k < nb; k++) begin
      for (int l = 0; l < 8; l++) begin
        b.dat[8*l +: 8] = (8*k + l < flen) ? fb[8*k + l] : 8'h00;
        b.keep[l]       = (8*k + l < flen);
      end
      b.last = (k == nb - 1);
      @(posedge clk156); #1;
      eth_rx_tvalid = 1'b1;
      eth_rx_tdata  = b.dat;
      eth_rx_tkeep  = b.keep;
      eth_rx_tlast  = b.last;
      eth_rx_tuser  = fuser_last && b.last;
      if (pass) exp_q.push_back(b);
    end
    @(posedge clk156); #1;
    eth_rx_tvalid = 1'b0;
    eth_rx_tlast  = 1'b0;
    eth_rx_tuser  = 1'b0;
    if (exp_ovf) begin
      m_ovf++;
      m_drop++;
    end else if (pass) m_pass++;
    else m_drop++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk156);
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    repeat (30) @(negedge clk156);
  endtask

  task automatic check_stats(input string name);
`ifdef ETH_RX_FILTER_STATS_EN
    check({name, "_pass_cnt"}, stat_pass_cnt, m_pass);
    check({name, "_drop_cnt"}, stat_drop_cnt, m_drop);
    check({name, "_ovf_cnt"},  stat_ovf_cnt,  m_ovf);
`else
    check({name, "_pass_cnt"}, stat_pass_cnt, 0);
    check({name, "_drop_cnt"}, stat_drop_cnt, 0);
    check({name, "_ovf_cnt"},  stat_ovf_cnt,  0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk156); #2;
    sys_rst156 = 1'b1;
    exp_q.delete();
    m_pass = 0; m_drop = 0; m_ovf = 0; out_cnt = 0;
    repeat (3) @(posedge clk156);
    #1 sys_rst156 = 1'b0;
  endtask

  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk156); #1;
      fil_rx_tready = stall_en ? (cyc % 3 != 0) : rdy_force;
      cyc++;
    end
  end

  // Output checker: every accepted beat against the model queue, plus hold-stable under stall.
  initial begin
    logic [79:0] prev;
    bit          held;
    beat_t       e;
    held = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk156);
      if (sys_rst156) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", fil_rx_tvalid, 1);
          check("hold_beat", {7'd0, fil_rx_tdata, fil_rx_tkeep, fil_rx_tlast}, prev);
        end
        if (fil_rx_tvalid && fil_rx_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h, no beat expected", fil_rx_tdata);
          end else begin
            e = exp_q.pop_front();
            check("out_beat", {7'd0, fil_rx_tdata, fil_rx_tkeep, fil_rx_tlast}, {7'd0, e});
          end
        end
        held = fil_rx_tvalid && !fil_rx_tready;
        prev = {7'd0, fil_rx_tdata, fil_rx_tkeep, fil_rx_tlast};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk156);
    #1 sys_rst156 = 1'b0;
    @(negedge clk156);
    check("reset_valid", fil_rx_tvalid, 0);
    check_stats("reset");

    // Matching 8-beat frame, dst port 0x3005
    build_base(60);
    check("model_good", model_pass(), 1);
    send_frame(0);
    check("beat0_literal", exp_q[0].dat, 64'h12110D0C0B0A0002);
    check("beat7_keep_literal", exp_q[7].keep, 8'h0F);
    lat = 1;
    while (lat <= 6) begin
      @(negedge clk156);
      if (fil_rx_tvalid) break;
      lat++;
    end
    check("first_beat_latency_le3", lat <= 3, 1);
    wait_drain("good");
    check("good_out_beats", out_cnt, 8);
    check_stats("good");

    // Wrong destination IP
    do_reset();
    build_base(60);
    fb[33] = 8'h02;
    check("model_bad_ip", model_pass(), 0);
    send_frame(0);
    wait_drain("bad_ip");
    check("bad_ip_out_beats", out_cnt, 0);
    check_stats("bad_ip");

    // tuser on last beat, then a good frame
    do_reset();
    build_base(60);
    fuser_last = 1'b1;
    send_frame(0);
    build_base(60);
    fb[40] = 8'hEE;
    send_frame(0);
    wait_drain("tuser");
    check("tuser_out_beats", out_cnt, 8);
    check_stats("tuser");

    // 4-beat runt, then a good frame under output stalls
    do_reset();
    build_base(32);
    check("model_runt", model_pass(), 0);
    stall_en = 1'b1;
    send_frame(0);
    build_base(60);
    fb[50] = 8'hA5;
    send_frame(0);
    wait_drain("runt");
    stall_en = 1'b0;
    check("runt_out_beats", out_cnt, 8);
    check_stats("runt");

    // 20-beat frame into a 16-deep FIFO with the output stalled
    do_reset();
    rdy_force = 1'b0;
    repeat (2) @(posedge clk156);
    build_base(160);
    send_frame(1);
    repeat (40) @(negedge clk156);
    check_stats("ovf_drop");
    rdy_force = 1'b1;
    repeat (2) @(posedge clk156);
    build_base(60);
    send_frame(0);
    wait_drain("ovf_next");
    check("ovf_out_beats", out_cnt, 8);
    check_stats("ovf_next");

    // Reset during output of a passed frame
    do_reset();
    build_base(60);
    send_frame(0);
    lat = 0;
    while (lat < 10 && !fil_rx_tvalid) begin
      @(negedge clk156);
      lat++;
    end
    check("pre_reset_valid", fil_rx_tvalid, 1);
    @(posedge clk156); #1;
    sys_rst156 = 1'b1;
    #1;
    check("reset_mid_valid", fil_rx_tvalid, 0);
    exp_q.delete();
    m_pass = 0; m_drop = 0; m_ovf = 0; out_cnt = 0;
    repeat (2) @(posedge clk156);
    #1 sys_rst156 = 1'b0;
    repeat (3) @(negedge clk156);
    check("after_reset_idle", fil_rx_tvalid, 0);
    build_base(60);
    fb[45] = 8'h3C;
    send_frame(0);
    wait_drain("post_reset");
    check("post_reset_out_beats", out_cnt, 8);
    check_stats("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
